gray_updown_counter: RTL

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

---
 rtl/gray_updown_counter.sv | 78 +++++++
 1 files changed

// File: rtl/gray_updown_counter.sv
// Up/down counter that keeps a binary and a Gray-coded copy of the count in lockstep.
// Supports wrap-around or saturation at the ends, synchronous load and async reset.
module gray_updown_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned WRAP      = 1,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] bin_cnt,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [WIDTH-1:0] MIN_VAL  = '0;
   localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
   localparam bit               WRAP_EN  = (WRAP != 0);

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic             at_max, at_min;

   assign at_max = (bin_q == MAX_VAL);
   assign at_min = (bin_q == MIN_VAL);

   // Terminal count follows the requested direction, regardless of enable.
   assign tc = up_dn ? at_max : at_min;

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_val;
      end else if (enable) begin
         if (up_dn) begin
            if (!at_max) begin
               bin_d = bin_q + WIDTH'(1);
            end else if (WRAP_EN) begin
               bin_d  = MIN_VAL;
               wrap_d = 1'b1;
            end
         end else begin
            if (!at_min) begin
               bin_d = bin_q - WIDTH'(1);
            end else if (WRAP_EN) begin
               bin_d  = MAX_VAL;
               wrap_d = 1'b1;
            end
         end
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bin_q  <= RST_BIN;
         gray_q <= RST_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin_cnt = bin_q;
   assign cnt     = gray_q;
   assign wrap    = wrap_q;

endmodule
